hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline's load-use hazard detector. It keeps a per-register countdown scoreboard of in-flight writes, so load-use and ECALL-source hazards are resolved for any load latency, not only one EX-stage slot. It sits in ID, drives PC/IF_ID write enables and the ID/EX bubble select, honours a global memory-freeze, and counts hazard stall cycles for performance debug.

Parameters:
REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W
LOAD_LAT, 1, cycles after issue before a load result is forwardable to ID (legal 1..7)
ECALL_LAT, 1, cycles after issue before a non-load write to ECALL_REG is visible to an ECALL in ID (legal 0..7)
ECALL_REG, 17, register an ECALL reads implicitly
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  source 1 index
id_rs2  in  REG_ADDR_W  source 2 index
id_use_rs1  in  1  instruction reads rs1 (from decoder)
id_use_rs2  in  1  instruction reads rs2 (from decoder)
id_is_ecall  in  1  instruction is ECALL
id_rd  in  REG_ADDR_W  destination index
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  branch/jump squash of ID this cycle
mem_stall  in  1  global pipeline freeze (cache miss)
pc_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
ID_EX_sel  out  1  1 = insert bubble into ID/EX
hazard_stall  out  1  scoreboard stall active this cycle
stall_cycles  out  CNT_W  saturating count of hazard_stall cycles

Behaviour:
- State: cnt[r] for r = 1..NUM_REGS-1, 3 bits each; cnt[0] constant 0. Plus stall_cycles.
- Reset: all cnt = 0, stall_cycles = 0. Outputs follow immediately: pc_write=1, IF_ID_write=1, ID_EX_sel=0, hazard_stall=0.
- Hazard (combinational, current state):
  - hz1 = id_use_rs1 & rs1!=0 & cnt[rs1]!=0
  - hz2 = id_use_rs2 & rs2!=0 & cnt[rs2]!=0
  - hze = id_is_ecall & cnt[ECALL_REG]!=0
  - hazard_stall = id_valid & ~flush & ~mem_stall & (hz1|hz2|hze)
- Outputs:
  - mem_stall=1: pc_write=0, IF_ID_write=0, ID_EX_sel=0 (freeze, no bubble).
  - Else hazard_stall=1: pc_write=0, IF_ID_write=0, ID_EX_sel=1.
  - Else: 1, 1, 0.
- issue = id_valid & ~flush & ~mem_stall & ~hazard_stall & id_reg_write & id_rd!=0.
- Counter update each posedge, if ~mem_stall:
  - every nonzero cnt decrements by 1;
  - then on issue, cnt[id_rd] is overwritten with LOAD_LAT if id_is_load, else ECALL_LAT if id_rd==ECALL_REG, else 0.
  - The overwrite wins over decrement. A younger writer replaces the older pending value (WAW; forwarding picks the youngest).
- mem_stall=1: all cnt hold, no issue, stall_cycles holds.
- stall_cycles increments on every cycle with hazard_stall=1 and saturates at all-ones.
- flush beats hazard: no stall, no issue that cycle. Counters still decrement.
- Reset mid-stall: next cycle all cnt are 0, so the stall releases.
- Latency: a consumer stalls exactly LOAD_LAT cycles when it immediately follows its load; it stalls LOAD_LAT-k cycles when k independent instructions sit between them.

Test Plan:
- LOAD_LAT=1, lw x5 then add x6,x5,x1 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_sel=1; add issues next cycle; stall_cycles=1.
- LOAD_LAT=3, lw x5; nop; add x7,x5,x5 -> two stall cycles; with lw x0 (rd=0) or id_use_rs2=0 on an x5-in-rs2-only consumer -> zero stalls.
- ECALL_LAT=1, addi x17,x0,10 then ecall -> one stall; lw x17 then ecall with LOAD_LAT=2 -> two stalls.
- LOAD_LAT=2, lw x5, then mem_stall high 4 cycles while add x6,x5 waits in ID -> outputs 0/0/0 during the freeze, cnt[x5] holds; after release, exactly the remaining stall cycles occur.
- lw x5 (LOAD_LAT=3) then addi x5 issued next cycle -> consumer of x5 after addi sees no stall (cnt overwritten to 0).
- Stall in progress, assert reset one cycle -> outputs 1/1/0 and stall_cycles=0 on the following cycle; flush during a hazard -> no stall that cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// ID-stage hazard detector built on a per-register countdown scoreboard.
// Every in-flight write to a register loads a small counter with the number
// of cycles until its result can be forwarded into ID; a consumer in ID that
// reads a register whose counter is nonzero is held (PC and IF/ID frozen,
// bubble into ID/EX). ECALL implicitly reads ECALL_REG. A global memory
// freeze holds everything, including the scoreboard. Hazard stall cycles are
// counted (saturating) for performance debug.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_rs1/id_rs2   source register indices
//   id_use_rs1/2    decoder says the source is actually read
//   id_is_ecall     instruction is ECALL (reads ECALL_REG)
//   id_rd           destination register index
//   id_reg_write    instruction writes id_rd
//   id_is_load      instruction is a load
//   flush           ID is squashed this cycle (branch/jump)
//   mem_stall       global pipeline freeze
//   pc_write        PC update enable
//   IF_ID_write     IF/ID register enable
//   ID_EX_sel       1 = insert bubble into ID/EX
//   hazard_stall    scoreboard stall active this cycle
//   stall_cycles    saturating count of hazard_stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int ECALL_LAT  = 1,
  parameter int ECALL_REG  = 17,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_ecall,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  mem_stall,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  ID_EX_sel,
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  localparam logic [2:0]            LOAD_CNT  = 3'(LOAD_LAT);
  localparam logic [2:0]            ECALL_CNT = 3'(ECALL_LAT);
  localparam logic [REG_ADDR_W-1:0] ECALL_IDX = REG_ADDR_W'(ECALL_REG);

  // Saturating increment for the performance counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  logic [2:0]       cnt_q [NUM_REGS];
  logic [2:0]       cnt_d [NUM_REGS];
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  logic hz1, hz2, hze;
  logic stall_w;
  logic active_w;
  logic issue_w;

  // Hazard detection against the current scoreboard state. x0 never hazards.
  always_comb begin
    hz1      = id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != 3'd0);
    hz2      = id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != 3'd0);
    hze      = id_is_ecall && (cnt_q[ECALL_IDX] != 3'd0);
    // flush and the freeze both mask the stall: a squashed or frozen
    // instruction must not bubble ID/EX.
    active_w = id_valid && !flush && !mem_stall;
    stall_w  = active_w && (hz1 || hz2 || hze);
    issue_w  = active_w && !stall_w && id_reg_write && (id_rd != '0);
  end

  // Pipeline control outputs; the freeze takes priority and inserts no bubble.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_sel    = 1'b0;
    hazard_stall = stall_w;
    if (mem_stall) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
    end else if (stall_w) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_sel   = 1'b1;
    end
  end

  // Scoreboard next state: age every pending write, then let a newly issued
  // writer overwrite its destination. Overwrite after decrement means the
  // youngest writer of a register determines when it becomes forwardable.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (!mem_stall) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cnt_q[r] != 3'd0) cnt_d[r] = cnt_q[r] - 3'd1;
      end
      if (issue_w) begin
        if (id_is_load)              cnt_d[id_rd] = LOAD_CNT;
        else if (id_rd == ECALL_IDX) cnt_d[id_rd] = ECALL_CNT;
        else                         cnt_d[id_rd] = 3'd0;
      end
    end
    cnt_d[0] = 3'd0;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_w) stall_cycles_d = sat_inc(stall_cycles_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= 3'd0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
